// File: rtl/ula_8_bits_scheduler.sv
// Shares one combinational ULA between two requesters: grant, hold operands, settle, capture, respond.
// Optional macro ULA_SCHED_RR_EN selects round-robin arbitration instead of fixed priority to requester 0.
module ula_8_bits_scheduler #(
  parameter int WIDTH         = 8,
  parameter int OP_W          = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ0_VALID,
  output logic             REQ0_READY,
  input  logic [WIDTH-1:0] REQ0_A,
  input  logic [WIDTH-1:0] REQ0_B,
  input  logic [OP_W-1:0]  REQ0_X,
  input  logic             REQ0_CIN,
  input  logic             REQ1_VALID,
  output logic             REQ1_READY,
  input  logic [WIDTH-1:0] REQ1_A,
  input  logic [WIDTH-1:0] REQ1_B,
  input  logic [OP_W-1:0]  REQ1_X,
  input  logic             REQ1_CIN,
  output logic [WIDTH-1:0] ULA_A,
  output logic [WIDTH-1:0] ULA_B,
  output logic [OP_W-1:0]  ULA_X,
  output logic             ULA_CIN,
  input  logic [WIDTH-1:0] ULA_S,
  input  logic             ULA_COUT,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic             RSP_ID,
  output logic [WIDTH-1:0] RSP_S,
  output logic             RSP_COUT,
  output logic             RSP_ERR,
  output logic             BUSY
);

  localparam int unsigned SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int unsigned CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
  localparam logic [OP_W-1:0] OP_ADD = '0;
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
  localparam logic [OP_W-1:0] OP_NOT = OP_W'(4);

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_RESP} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a, r_b, r_rsp_s;
  logic [OP_W-1:0]    r_x;
  logic               r_cin, r_id, r_last_grant;
  logic               r_rsp_valid, r_rsp_cout, r_rsp_err;

  logic               w_any, w_grant, w_legal, w_arith;
  logic               w_accept, w_capture, w_rsp_hs;
  logic [WIDTH-1:0]   w_sel_a, w_sel_b;
  logic [OP_W-1:0]    w_sel_x;
  logic               w_sel_cin;

  assign w_any = REQ0_VALID | REQ1_VALID;

  // With no requester valid the grant is a don't-care; last_grant fills it so it is always read.
  always_comb begin
    w_grant = r_last_grant;
`ifdef ULA_SCHED_RR_EN
    if (REQ0_VALID && REQ1_VALID) w_grant = ~r_last_grant;
    else if (REQ0_VALID)          w_grant = 1'b0;
    else if (REQ1_VALID)          w_grant = 1'b1;
`else
    if (REQ0_VALID)      w_grant = 1'b0;
    else if (REQ1_VALID) w_grant = 1'b1;
`endif
  end

  assign w_sel_a   = w_grant ? REQ1_A   : REQ0_A;
  assign w_sel_b   = w_grant ? REQ1_B   : REQ0_B;
  assign w_sel_x   = w_grant ? REQ1_X   : REQ0_X;
  assign w_sel_cin = w_grant ? REQ1_CIN : REQ0_CIN;
  assign w_legal   = (w_sel_x <= OP_NOT);
  assign w_arith   = (r_x == OP_ADD) || (r_x == OP_SUB);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // READY is gated by RST_N so every output reads 0 while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    REQ0_READY  = 1'b0;
    REQ1_READY  = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_rsp_hs    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (RST_N && w_any) begin
          REQ0_READY  = ~w_grant;
          REQ1_READY  = w_grant;
          w_accept    = 1'b1;
          w_state_nxt = w_legal ? ST_DRIVE : ST_RESP;
        end
      end
      ST_DRIVE: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (r_rsp_valid && RSP_READY) begin
          w_rsp_hs    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Illegal opcodes leave the ULA operand registers untouched and respond directly.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_a          <= '0;
      r_b          <= '0;
      r_x          <= '0;
      r_cin        <= 1'b0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_s      <= '0;
      r_rsp_cout   <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_id         <= w_grant;
        r_last_grant <= w_grant;
        if (w_legal) begin
          r_a   <= w_sel_a;
          r_b   <= w_sel_b;
          r_x   <= w_sel_x;
          r_cin <= w_sel_cin;
          r_cnt <= CNT_W'(SETTLE_EFF - 1);
        end else begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b1;
          r_rsp_s     <= '0;
          r_rsp_cout  <= 1'b0;
        end
      end
      if (r_state == ST_DRIVE && !w_capture) r_cnt <= r_cnt - CNT_W'(1);
      if (w_capture) begin
        r_rsp_valid <= 1'b1;
        r_rsp_s     <= ULA_S;
        r_rsp_cout  <= w_arith & ULA_COUT;
        r_rsp_err   <= 1'b0;
      end
      if (w_rsp_hs) r_rsp_valid <= 1'b0;
    end
  end

  assign ULA_A     = r_a;
  assign ULA_B     = r_b;
  assign ULA_X     = r_x;
  assign ULA_CIN   = r_cin;
  assign RSP_VALID = r_rsp_valid;
  assign RSP_ID    = r_id;
  assign RSP_S     = r_rsp_s;
  assign RSP_COUT  = r_rsp_cout;
  assign RSP_ERR   = r_rsp_err;
  assign BUSY      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ula_8_bits_scheduler.sv
// Directed bench: SETTLE_CYCLES=1 instance for arbitration/handshake, SETTLE_CYCLES=3 instance for settle and mid-op reset.
module tb_ula_8_bits_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0, d3_req0_valid = 1'b0, d3_req1_valid = 1'b0;
  logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0] req0_x = '0, req1_x = '0;
  logic       req0_cin = 1'b0, req1_cin = 1'b0, rsp_ready = 1'b1;

  logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout, rsp_err, busy, ula_cin, ula_cout;
  logic [7:0] ula_a, ula_b, ula_s, rsp_s;
  logic [2:0] ula_x;
  logic       d3_req0_ready, d3_req1_ready, d3_rsp_valid, d3_rsp_id, d3_rsp_cout, d3_rsp_err, d3_busy;
  logic       d3_ula_cin, d3_ula_cout;
  logic [7:0] d3_ula_a, d3_ula_b, d3_ula_s, d3_rsp_s;
  logic [2:0] d3_ula_x;

  int total = 0;
  int bad = 0;

  // ULA stub drives carry 1 on logic ops so masking of RSP_COUT is observable.
  function automatic logic [8:0] ula_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] x, input logic cin);
    case (x)
      3'b000:  return {1'b0, a} + {1'b0, b} + {8'b0, cin};
      3'b001:  return {1'b0, a} - {1'b0, b} - {8'b0, cin};
      3'b010:  return {1'b1, a & b};
      3'b011:  return {1'b1, a | b};
      3'b100:  return {1'b1, ~a};
      default: return {1'b1, 8'hEE};
    endcase
  endfunction

  assign {ula_cout, ula_s}       = ula_model(ula_a, ula_b, ula_x, ula_cin);
  assign {d3_ula_cout, d3_ula_s} = ula_model(d3_ula_a, d3_ula_b, d3_ula_x, d3_ula_cin);

  always #5 clk = ~clk;

  ula_8_bits_scheduler #(.WIDTH(8), .OP_W(3), .SETTLE_CYCLES(1)) u_dut (
    .CLK(clk), .RST_N(rst_n),
    .REQ0_VALID(req0_valid), .REQ0_READY(req0_ready), .REQ0_A(req0_a), .REQ0_B(req0_b),
    .REQ0_X(req0_x), .REQ0_CIN(req0_cin),
    .REQ1_VALID(req1_valid), .REQ1_READY(req1_ready), .REQ1_A(req1_a), .REQ1_B(req1_b),
    .REQ1_X(req1_x), .REQ1_CIN(req1_cin),
    .ULA_A(ula_a), .ULA_B(ula_b), .ULA_X(ula_x), .ULA_CIN(ula_cin),
    .ULA_S(ula_s), .ULA_COUT(ula_cout),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_ID(rsp_id), .RSP_S(rsp_s),
    .RSP_COUT(rsp_cout), .RSP_ERR(rsp_err), .BUSY(busy)
  );

  ula_8_bits_scheduler #(.WIDTH(8), .OP_W(3), .SETTLE_CYCLES(3)) u_dut3 (
    .CLK(clk), .RST_N(rst_n),
    .REQ0_VALID(d3_req0_valid), .REQ0_READY(d3_req0_ready), .REQ0_A(req0_a), .REQ0_B(req0_b),
    .REQ0_X(req0_x), .REQ0_CIN(req0_cin),
    .REQ1_VALID(d3_req1_valid), .REQ1_READY(d3_req1_ready), .REQ1_A(req1_a), .REQ1_B(req1_b),
    .REQ1_X(req1_x), .REQ1_CIN(req1_cin),
    .ULA_A(d3_ula_a), .ULA_B(d3_ula_b), .ULA_X(d3_ula_x), .ULA_CIN(d3_ula_cin),
    .ULA_S(d3_ula_s), .ULA_COUT(d3_ula_cout),
    .RSP_VALID(d3_rsp_valid), .RSP_READY(rsp_ready), .RSP_ID(d3_rsp_id), .RSP_S(d3_rsp_s),
    .RSP_COUT(d3_rsp_cout), .RSP_ERR(d3_rsp_err), .BUSY(d3_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int budget);
    for (int n = 0; n < budget && !rsp_valid; n++) tick();
    chk("rsp_wait", rsp_valid, 1);
  endtask

  task automatic wait_rsp3(input int budget);
    for (int n = 0; n < budget && !d3_rsp_valid; n++) tick();
    chk("rsp3_wait", d3_rsp_valid, 1);
  endtask

  // Presents one request on the SETTLE_CYCLES=1 instance and returns just after the accept edge.
  task automatic issue(input logic who, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] x, input logic cin);
    if (who) begin
      req1_a = a; req1_b = b; req1_x = x; req1_cin = cin; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_x = x; req0_cin = cin; req0_valid = 1'b1;
    end
    #1;
    for (int n = 0; n < 20 && !(who ? req1_ready : req0_ready); n++) tick();
    chk("issue_grant", who ? req1_ready : req0_ready, 1);
    tick();
    if (who) req1_valid = 1'b0;
    else     req0_valid = 1'b0;
  endtask

  initial begin
    logic [2:0] exp_ids;
`ifdef ULA_SCHED_RR_EN
    exp_ids = 3'b010;
`else
    exp_ids = 3'b000;
`endif

    // Reset held with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'($urandom); req1_valid = 1'($urandom);
      d3_req0_valid = 1'($urandom); d3_req1_valid = 1'($urandom);
      req0_a = 8'($urandom); req0_b = 8'($urandom); req0_x = 3'($urandom);
      req1_a = 8'($urandom); req1_b = 8'($urandom); req1_x = 3'($urandom);
      rsp_ready = 1'($urandom);
      tick();
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_ula_a", ula_a, 0);
    chk("rst_rsp_s", rsp_s, 0);
    chk("rst_d3_busy", d3_busy, 0);
    req0_valid = 1'b0; req1_valid = 1'b0; d3_req0_valid = 1'b0; d3_req1_valid = 1'b0;
    rsp_ready = 1'b1;
    rst_n = 1'b1;
    tick();

    // Lone req1 after reset: or 0x0F|0x30
    req1_a = 8'h0F; req1_b = 8'h30; req1_x = 3'b011; req1_cin = 1'b0; req1_valid = 1'b1;
    #1;
    chk("lone1_ready1", req1_ready, 1);
    chk("lone1_ready0", req0_ready, 0);
    tick();
    req1_valid = 1'b0;
    wait_rsp(5);
    chk("lone1_s", rsp_s, 8'h3F);
    chk("lone1_id", rsp_id, 1);
    chk("lone1_cout", rsp_cout, 0);
    chk("lone1_err", rsp_err, 0);
    tick();
    chk("lone1_drop", rsp_valid, 0);

    // Both valid, each drops once accepted
    req0_a = 8'h83; req0_b = 8'h01; req0_x = 3'b001; req0_cin = 1'b0; req0_valid = 1'b1;
    req1_a = 8'h83; req1_b = 8'h01; req1_x = 3'b010; req1_cin = 1'b0; req1_valid = 1'b1;
    #1;
    chk("cont_ready0", req0_ready, 1);
    chk("cont_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    chk("cont_drive_ready1", req1_ready, 0);
    chk("cont_drive_busy", busy, 1);
    wait_rsp(5);
    chk("cont_sub_s", rsp_s, 8'h82);
    chk("cont_sub_id", rsp_id, 0);
    tick();
    chk("cont_next_ready1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    wait_rsp(5);
    chk("cont_and_s", rsp_s, 8'h01);
    chk("cont_and_id", rsp_id, 1);
    chk("cont_and_cout", rsp_cout, 0);
    tick();

    // Both valid continuously for three grants
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int g = 0; g < 3; g++) begin
      #1;
      chk("arb_any", req0_ready | req1_ready, 1);
      chk("arb_grant", req1_ready, exp_ids[g]);
      tick();
      wait_rsp(5);
      chk("arb_rsp_id", rsp_id, exp_ids[g]);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // Req0 add with exact latency
    req0_a = 8'h83; req0_b = 8'h01; req0_x = 3'b000; req0_cin = 1'b0; req0_valid = 1'b1;
    #1;
    chk("add_ready0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    chk("add_not_yet", rsp_valid, 0);
    chk("add_ula_a", ula_a, 8'h83);
    chk("add_ula_b", ula_b, 8'h01);
    chk("add_ula_x", ula_x, 3'b000);
    tick();
    chk("add_valid", rsp_valid, 1);
    chk("add_s", rsp_s, 8'h84);
    chk("add_cout", rsp_cout, 0);
    chk("add_id", rsp_id, 0);
    chk("add_err", rsp_err, 0);
    tick();
    chk("add_idle", busy, 0);

    // Add overflow wraps: 0xFF+0x01+1
    issue(1'b0, 8'hFF, 8'h01, 3'b000, 1'b1);
    wait_rsp(5);
    chk("ovf_s", rsp_s, 8'h01);
    chk("ovf_cout", rsp_cout, 1);
    tick();

    // Backpressure, with a competing request held through the handshake
    rsp_ready = 1'b0;
    issue(1'b1, 8'h83, 8'h01, 3'b011, 1'b0);
    wait_rsp(5);
    req0_a = 8'h10; req0_b = 8'h20; req0_x = 3'b000; req0_cin = 1'b0; req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_s", rsp_s, 8'h83);
      chk("bp_busy", busy, 1);
      chk("bp_ready0", req0_ready, 0);
      chk("bp_ready1", req1_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_drop", rsp_valid, 0);
    chk("bp_idle", busy, 0);
    chk("bp_wait_ready0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    chk("bp_next_busy", busy, 1);
    wait_rsp(5);
    chk("bp_next_s", rsp_s, 8'h30);
    chk("bp_next_id", rsp_id, 0);
    tick();

    // Illegal opcode, then not
    issue(1'b0, 8'h55, 8'h0F, 3'b101, 1'b0);
    wait_rsp(4);
    chk("ill_err", rsp_err, 1);
    chk("ill_s", rsp_s, 0);
    chk("ill_cout", rsp_cout, 0);
    chk("ill_ula_x", ula_x, 3'b000);
    chk("ill_ula_a", ula_a, 8'h10);
    tick();
    issue(1'b0, 8'h83, 8'h00, 3'b100, 1'b0);
    wait_rsp(5);
    chk("not_s", rsp_s, 8'h7C);
    chk("not_cout", rsp_cout, 0);
    chk("not_err", rsp_err, 0);
    tick();

    // SETTLE_CYCLES=3: capture three edges after accept
    req0_a = 8'h01; req0_b = 8'h02; req0_x = 3'b000; req0_cin = 1'b0; d3_req0_valid = 1'b1;
    #1;
    chk("s3_ready0", d3_req0_ready, 1);
    tick();
    d3_req0_valid = 1'b0;
    tick();
    chk("s3_k1", d3_rsp_valid, 0);
    tick();
    chk("s3_k2", d3_rsp_valid, 0);
    tick();
    chk("s3_k3", d3_rsp_valid, 1);
    chk("s3_s", d3_rsp_s, 8'h03);
    tick();
    chk("s3_drop", d3_rsp_valid, 0);

    // Reset during DRIVE abandons the operation
    req0_a = 8'h40; req0_b = 8'h02; req0_x = 3'b001; d3_req0_valid = 1'b1;
    tick();
    d3_req0_valid = 1'b0;
    tick();
    chk("s3_drive_busy", d3_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("s3_rst_busy", d3_busy, 0);
    chk("s3_rst_valid", d3_rsp_valid, 0);
    chk("s3_rst_ula_a", d3_ula_a, 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s3_no_rsp", d3_rsp_valid, 0);
    end
    req1_a = 8'h20; req1_b = 8'h05; req1_x = 3'b000; req1_cin = 1'b0; d3_req1_valid = 1'b1;
    #1;
    chk("s3_post_ready1", d3_req1_ready, 1);
    tick();
    d3_req1_valid = 1'b0;
    wait_rsp3(6);
    chk("s3_post_s", d3_rsp_s, 8'h25);
    chk("s3_post_id", d3_rsp_id, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
